// File: rtl/sprite_ram_writer_if.sv
// Command and pixel-stream handshake bundle for sprite_ram_writer.
// master drives requests; slave (the writer) drives the readies.
interface sprite_ram_writer_if #(
  parameter int IDX_BITS = 5
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [IDX_BITS-1:0] cmd_color;
  logic [4:0]          cmd_x;
  logic [5:0]          cmd_y;
  logic                px_valid;
  logic                px_ready;
  logic [IDX_BITS-1:0] px_data;
  logic                px_last;

  modport master (
    output cmd_valid, cmd_op, cmd_color,
    output cmd_x, cmd_y,
    output px_valid, px_data, px_last,
    input  cmd_ready, px_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_color,
    input  cmd_x, cmd_y,
    input  px_valid, px_data, px_last,
    output cmd_ready, px_ready
  );
endinterface

// File: rtl/sprite_ram_writer.sv
// Sprite index RAM with LOAD/FILL/POKE write engine and 1-cycle read port.
// Ports: vga_clk, reset_n, bus (cmd/px), busy, done, err, rd_address, rd_q.
module sprite_ram_writer #(
  parameter int WIDTH     = 21,
  parameter int HEIGHT    = 45,
  parameter int IDX_BITS  = 5,
  parameter int ADDR_BITS = 11
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  sprite_ram_writer_if.slave   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic [ADDR_BITS-1:0] rd_address,
  output logic [IDX_BITS-1:0]  rd_q
);

  localparam int N = WIDTH * HEIGHT;
  localparam logic [ADDR_BITS-1:0] LAST =
    ADDR_BITS'(N - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, FILL, POKE, DONE
  } state_t;

  state_t               state, state_n;
  logic [ADDR_BITS-1:0] cnt, cnt_n;
  logic [IDX_BITS-1:0]  color, color_n;
  logic [4:0]           x, x_n;
  logic [5:0]           y, y_n;
  logic                 err_n;

  logic                 we;
  logic [ADDR_BITS-1:0] wa;
  logic [IDX_BITS-1:0]  wd;
  logic                 poke_ok;
  logic [ADDR_BITS-1:0] poke_addr;

  logic [IDX_BITS-1:0] mem [2**ADDR_BITS];

  assign poke_ok   = (int'(x) < WIDTH) &&
                     (int'(y) < HEIGHT);
  assign poke_addr = ADDR_BITS'(x) +
                     ADDR_BITS'(y) *
                     ADDR_BITS'(WIDTH);

  assign bus.cmd_ready = (state == IDLE);
  assign bus.px_ready  = (state == LOAD);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
      color <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err   <= err_n;
      color <= color_n;
      x     <= x_n;
      y     <= y_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = err;
    color_n = color;
    x_n     = x;
    y_n     = y;
    we      = 1'b0;
    wa      = cnt;
    wd      = color;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          cnt_n   = '0;
          err_n   = 1'b0;
          color_n = bus.cmd_color;
          x_n     = bus.cmd_x;
          y_n     = bus.cmd_y;
          unique case (bus.cmd_op)
            2'd0: state_n = LOAD;
            2'd1: state_n = FILL;
            2'd2: state_n = POKE;
            default: begin
              err_n   = 1'b1;
              state_n = DONE;
            end
          endcase
        end
      end
      LOAD: begin
        if (bus.px_valid) begin
          we = 1'b1;
          wd = bus.px_data;
          if (cnt == LAST) begin
            state_n = DONE;
            if (!bus.px_last) err_n = 1'b1;
          end else if (bus.px_last) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      FILL: begin
        we = 1'b1;
        if (cnt == LAST) state_n = DONE;
        else cnt_n = cnt + 1'b1;
      end
      POKE: begin
        wa = poke_addr;
        if (poke_ok) we = 1'b1;
        else err_n = 1'b1;
        state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A write on the reset edge is dropped so an abort is clean.
  always_ff @(posedge vga_clk) begin
    if (reset_n && we) mem[wa] <= wd;
  end

  // Read-before-write: same-address access returns old data.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) rd_q <= '0;
    else if (int'(rd_address) < N)
      rd_q <= mem[rd_address];
    else rd_q <= '0;
  end

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Randomized self-checking bench for sprite_ram_writer.
// Compares against an array model of the sprite RAM.
module tb_sprite_ram_writer;

  localparam int N = 945;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic        busy, done, err;
  logic [10:0] rd_address;
  logic [4:0]  rd_q;

  int checks = 0;
  int errors = 0;
  logic [4:0] model [0:N-1];

  sprite_ram_writer_if #(.IDX_BITS(5)) bus ();

  sprite_ram_writer dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rd_address (rd_address),
    .rd_q       (rd_q)
  );

  always #5 vga_clk = ~vga_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.cmd_valid = 0;
    bus.cmd_op    = 0;
    bus.cmd_color = 0;
    bus.cmd_x     = 0;
    bus.cmd_y     = 0;
    bus.px_valid  = 0;
    bus.px_data   = 0;
    bus.px_last   = 0;
  endtask

  task automatic rd(input int a, output logic [4:0] q);
    @(negedge vga_clk);
    rd_address = 11'(a);
    @(negedge vga_clk);
    q = rd_q;
  endtask

  // Returns at the first negedge after the accepting edge.
  task automatic send_cmd(input logic [1:0] op,
                          input logic [4:0] c,
                          input logic [4:0] x,
                          input logic [5:0] y,
                          output logic rdy);
    @(negedge vga_clk);
    rdy = bus.cmd_ready;
    bus.cmd_valid = 1;
    bus.cmd_op    = op;
    bus.cmd_color = c;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
    @(negedge vga_clk);
    bus.cmd_valid = 0;
  endtask

  task automatic wait_done(inout int lat);
    while (done !== 1'b1 && lat < 3000) begin
      @(negedge vga_clk);
      lat++;
    end
  endtask

  task automatic test_read_back(input string tag);
    logic [4:0] q;
    int a;
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, N - 1);
      rd(a, q);
      checks++;
      if (q !== model[a]) begin
        errors++;
        $display("FAIL %s rd[%0d] got %h want %h",
                 tag, a, q, model[a]);
      end
    end
    a = $urandom_range(N, 2047);
    rd(a, q);
    checks++;
    if (q !== 5'h0) begin
      errors++;
      $display("FAIL %s oob rd[%0d] got %h want 0",
               tag, a, q);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_address = 0;
    reset_n = 0;
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    checks += 6;
    if (busy !== 0) begin errors++;
      $display("FAIL reset busy got %b want 0", busy); end
    if (done !== 0) begin errors++;
      $display("FAIL reset done got %b want 0", done); end
    if (err !== 0) begin errors++;
      $display("FAIL reset err got %b want 0", err); end
    if (rd_q !== 0) begin errors++;
      $display("FAIL reset rd_q got %h want 0", rd_q); end
    if (bus.cmd_ready !== 1) begin errors++;
      $display("FAIL reset cmd_ready got %b want 1",
               bus.cmd_ready); end
    if (bus.px_ready !== 0) begin errors++;
      $display("FAIL reset px_ready got %b want 0",
               bus.px_ready); end
    reset_n = 1;
  endtask

  task automatic test_fill(input logic [4:0] c);
    logic rdy;
    logic [4:0] q;
    int lat;
    int addrs [3] = '{0, 472, 944};
    send_cmd(2'd1, c, 0, 0, rdy);
    lat = 1;
    checks += 3;
    if (rdy !== 1) begin errors++;
      $display("FAIL fill ready got %b want 1", rdy); end
    if (busy !== 1 || bus.cmd_ready !== 0) begin
      errors++;
      $display("FAIL fill busy/ready got %b/%b want 1/0",
               busy, bus.cmd_ready); end
    wait_done(lat);
    if (lat !== 946) begin errors++;
      $display("FAIL fill latency got %0d want 946", lat); end
    checks++;
    if (err !== 0) begin errors++;
      $display("FAIL fill err got %b want 0", err); end
    @(negedge vga_clk);
    checks++;
    if (done !== 0 || bus.cmd_ready !== 1) begin
      errors++;
      $display("FAIL fill done_pulse done %b rdy %b want 0 1",
               done, bus.cmd_ready); end
    for (int i = 0; i < N; i++) model[i] = c;
    foreach (addrs[k]) begin
      rd(addrs[k], q);
      checks++;
      if (q !== c) begin errors++;
        $display("FAIL fill rd[%0d] got %h want %h",
                 addrs[k], q, c); end
    end
    test_read_back("fill");
  endtask

  task automatic test_load(input int npx, input int last_at,
                           input bit rnd, input logic exp_err,
                           input string tag);
    logic rdy;
    logic v;
    logic [4:0] d;
    int i, guard;
    send_cmd(2'd0, 0, 0, 0, rdy);
    checks++;
    if (rdy !== 1) begin errors++;
      $display("FAIL %s ready got %b want 1", tag, rdy); end
    i = 0;
    guard = 0;
    while (i < npx && guard < 20000) begin
      v = 1'($urandom_range(0, 1));
      d = rnd ? 5'($urandom) : 5'(i);
      bus.px_valid = v;
      bus.px_data  = d;
      bus.px_last  = (i == last_at);
      checks++;
      if (bus.px_ready !== 1) begin errors++;
        $display("FAIL %s px_ready got %b want 1",
                 tag, bus.px_ready); end
      @(negedge vga_clk);
      if (v) begin
        model[i] = d;
        i++;
      end
      guard++;
    end
    bus.px_valid = 0;
    bus.px_last  = 0;
    checks += 4;
    if (guard >= 20000) begin errors++;
      $display("FAIL %s stream timeout sent %0d want %0d",
               tag, i, npx); end
    if (done !== 1) begin errors++;
      $display("FAIL %s done got %b want 1", tag, done); end
    if (err !== exp_err) begin errors++;
      $display("FAIL %s err got %b want %b",
               tag, err, exp_err); end
    if (bus.px_ready !== 0) begin errors++;
      $display("FAIL %s px_ready after got %b want 0",
               tag, bus.px_ready); end
    @(negedge vga_clk);
    checks++;
    if (done !== 0 || bus.cmd_ready !== 1) begin
      errors++;
      $display("FAIL %s done_pulse done %b rdy %b want 0 1",
               tag, done, bus.cmd_ready); end
  endtask

  task automatic test_load_full();
    logic [4:0] q;
    test_load(N, N - 1, 0, 1'b0, "load_full");
    rd(500, q);
    checks++;
    if (q !== 5'h14) begin errors++;
      $display("FAIL load rd[500] got %h want 14", q); end
    rd(944, q);
    checks++;
    if (q !== 5'h10) begin errors++;
      $display("FAIL load rd[944] got %h want 10", q); end
    test_read_back("load_full");
  endtask

  task automatic test_load_short();
    logic [4:0] q;
    test_load(101, 100, 1, 1'b1, "load_short");
    rd(100, q);
    checks++;
    if (q !== model[100]) begin errors++;
      $display("FAIL short rd[100] got %h want %h",
               q, model[100]); end
    rd(101, q);
    checks++;
    if (q !== 5'd5) begin errors++;
      $display("FAIL short rd[101] got %h want 05", q); end
    test_read_back("load_short");
  endtask

  task automatic test_load_nolast();
    test_load(N, -1, 1, 1'b1, "load_nolast");
    test_read_back("load_nolast");
  endtask

  task automatic test_poke();
    logic rdy;
    logic [4:0] q, c, px;
    logic [5:0] py;
    int lat;
    send_cmd(2'd2, 5'd3, 5'd20, 6'd44, rdy);
    lat = 1;
    wait_done(lat);
    checks += 2;
    if (lat !== 2) begin errors++;
      $display("FAIL poke latency got %0d want 2", lat); end
    if (err !== 0) begin errors++;
      $display("FAIL poke err got %b want 0", err); end
    model[944] = 5'd3;
    rd(944, q);
    checks++;
    if (q !== 5'd3) begin errors++;
      $display("FAIL poke rd[944] got %h want 03", q); end
    send_cmd(2'd2, 5'd9, 5'd21, 6'd0, rdy);
    lat = 1;
    wait_done(lat);
    checks += 2;
    if (lat !== 2) begin errors++;
      $display("FAIL poke_oob latency got %0d want 2", lat); end
    if (err !== 1) begin errors++;
      $display("FAIL poke_oob err got %b want 1", err); end
    rd(21, q);
    checks++;
    if (q !== model[21]) begin errors++;
      $display("FAIL poke_oob rd[21] got %h want %h",
               q, model[21]); end
    send_cmd(2'd2, 5'd9, 5'd0, 6'd45, rdy);
    lat = 1;
    wait_done(lat);
    checks++;
    if (err !== 1) begin errors++;
      $display("FAIL poke_oob_y err got %b want 1", err); end
    for (int k = 0; k < 4; k++) begin
      px = 5'($urandom_range(0, 20));
      py = 6'($urandom_range(0, 44));
      c  = 5'($urandom);
      send_cmd(2'd2, c, px, py, rdy);
      checks++;
      if (err !== 0) begin errors++;
        $display("FAIL poke_clr err got %b want 0", err); end
      lat = 1;
      wait_done(lat);
      model[int'(px) + int'(py) * 21] = c;
      rd(int'(px) + int'(py) * 21, q);
      checks++;
      if (q !== c) begin errors++;
        $display("FAIL poke_rnd (%0d,%0d) got %h want %h",
                 px, py, q, c); end
    end
    test_read_back("poke");
  endtask

  task automatic test_reserved();
    logic rdy;
    send_cmd(2'd3, 5'h1F, 0, 0, rdy);
    checks++;
    if (done !== 1 || err !== 1) begin errors++;
      $display("FAIL reserved done/err got %b/%b want 1/1",
               done, err); end
    @(negedge vga_clk);
    checks++;
    if (bus.cmd_ready !== 1 || done !== 0) begin errors++;
      $display("FAIL reserved after rdy %b done %b want 1 0",
               bus.cmd_ready, done); end
  endtask

  task automatic test_rdw();
    logic rdy;
    logic [4:0] old, nc, q;
    int lat;
    old = model[7];
    nc  = (old == 5'h15) ? 5'h0B : 5'h15;
    send_cmd(2'd1, nc, 0, 0, rdy);
    lat = 1;
    checks++;
    if (err !== 0) begin errors++;
      $display("FAIL rdw err_clear got %b want 0", err); end
    repeat (7) begin @(negedge vga_clk); lat++; end
    rd_address = 11'd7;
    @(negedge vga_clk); lat++;
    checks++;
    if (rd_q !== old) begin errors++;
      $display("FAIL rdw same_cycle got %h want %h",
               rd_q, old); end
    @(negedge vga_clk); lat++;
    checks++;
    if (rd_q !== nc) begin errors++;
      $display("FAIL rdw next got %h want %h", rd_q, nc); end
    bus.cmd_valid = 1;
    bus.cmd_op    = 2'd2;
    bus.cmd_color = ~nc;
    checks++;
    if (bus.cmd_ready !== 0) begin errors++;
      $display("FAIL busy_cmd ready got %b want 0",
               bus.cmd_ready); end
    @(negedge vga_clk); lat++;
    bus.cmd_valid = 0;
    wait_done(lat);
    checks++;
    if (lat !== 946) begin errors++;
      $display("FAIL rdw fill latency got %0d want 946", lat); end
    for (int i = 0; i < N; i++) model[i] = nc;
    @(negedge vga_clk);
    test_read_back("rdw");
  endtask

  task automatic test_reset_mid();
    logic rdy;
    logic [4:0] old, nc, q;
    bit saw_done;
    old = model[0];
    nc  = old ^ 5'h1F;
    send_cmd(2'd1, nc, 0, 0, rdy);
    repeat (300) @(negedge vga_clk);
    reset_n = 0;
    @(negedge vga_clk);
    reset_n = 1;
    checks++;
    if (busy !== 0 || done !== 0 ||
        bus.cmd_ready !== 1) begin errors++;
      $display("FAIL mid_reset busy %b done %b rdy %b want 0 0 1",
               busy, done, bus.cmd_ready); end
    saw_done = 0;
    repeat (5) begin
      @(negedge vga_clk);
      if (done === 1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++;
      $display("FAIL mid_reset done got 1 want 0"); end
    for (int i = 0; i < 300; i++) model[i] = nc;
    rd(299, q);
    checks++;
    if (q !== nc) begin errors++;
      $display("FAIL mid_reset rd[299] got %h want %h", q, nc); end
    rd(301, q);
    checks++;
    if (q !== old) begin errors++;
      $display("FAIL mid_reset rd[301] got %h want %h", q, old); end
    rd(0, q);
    checks++;
    if (q !== nc) begin errors++;
      $display("FAIL mid_reset rd[0] got %h want %h", q, nc); end
  endtask

  initial begin
    test_reset();
    test_fill(5'h0A);
    test_load_full();
    test_load_short();
    test_load_nolast();
    test_poke();
    test_reserved();
    test_rdw();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_ram_writer.md
Name: sprite_ram_writer

Overview:
- Writer side of the sprite index memory that the per-sprite mappers read.
- Owns a dual-port sprite RAM of WIDTH*HEIGHT palette indices (row-major, address = x + y*WIDTH).
- Write port is driven by a command engine: stream load, solid fill, or single-pixel poke. The read port serves the mapper with 1-cycle registered latency, matching the mapper's ROM timing so this block can replace a sprite ROM.

Parameters:
WIDTH, 21, sprite width in pixels
HEIGHT, 45, sprite height in rows
IDX_BITS, 5, palette index width
ADDR_BITS, 11, address width; must satisfy 2**ADDR_BITS >= WIDTH*HEIGHT

Ports:
vga_clk  in  1  sole clock, rising edge
reset_n  in  1  synchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  0=LOAD stream, 1=FILL, 2=POKE, 3=reserved
cmd_color  in  IDX_BITS  fill/poke index
cmd_x  in  5  poke column
cmd_y  in  6  poke row
px_valid  in  1  stream pixel valid
px_ready  out  1  high only in LOAD
px_data  in  IDX_BITS  stream pixel index, row-major order
px_last  in  1  marks final stream pixel
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at command completion
err  out  1  sticky error, cleared on next command accept
rd_address  in  ADDR_BITS  mapper read address
rd_q  out  IDX_BITS  registered read data

Behaviour:
- Reset (reset_n=0 at an edge) forces state=IDLE, wr counter=0, busy=0, done=0, err=0, rd_q=0. RAM contents are not cleared. Reset mid-command aborts it immediately; the partially written RAM is kept and no done pulse is issued.
- Handshakes: cmd accepted on cmd_valid&&cmd_ready; px accepted on px_valid&&px_ready. No combinational path from valid to ready.
- FSM states: IDLE, LOAD, FILL, POKE, DONE.
- IDLE:
  - On accept, latch op, color, x and y, clear err and cnt.
  - Go to LOAD, FILL or POKE by op.
  - op=3: set err, go to DONE.
- LOAD:
  - Each accepted px writes px_data to mem[cnt]; cnt increments.
  - No accept means no write; the stall may last any length.
  - px_last accepted with cnt<N-1 (N=WIDTH*HEIGHT): write that pixel, set err, go to DONE.
  - Pixel at cnt=N-1 accepted: write it, go to DONE. If px_last=0 on that pixel, set err.
- FILL:
  - One write per cycle of the latched color to mem[cnt], cnt 0..N-1, then DONE.
  - Exactly N cycles in FILL.
- POKE:
  - One cycle. If x<WIDTH and y<HEIGHT, write color to mem[x + y*WIDTH].
  - Otherwise no write and set err. Then DONE.
  - Address arithmetic uses ADDR_BITS width, no truncation for legal coordinates.
- DONE: done=1 for exactly this cycle, busy=1, then IDLE. cmd_ready returns the cycle after.
- Read port:
  - Every cycle, rd_q <= mem[rd_address], independent of the write side and of busy.
  - rd_address>=N returns 0.
  - Read and write to the same address in the same cycle returns the old data; the new data is visible on the next read.
- Latency: POKE accept to done = 2 cycles. FILL accept to done = N+1 cycles. LOAD completes 1 cycle after the final accepted pixel.
- Simultaneous events: cmd_valid during busy is ignored (not accepted, not queued). px_valid outside LOAD is ignored (px_ready=0).

Test Plan:
- Reset with reset_n=0 for 2 cycles -> busy=0, done=0, err=0, rd_q=0, cmd_ready=1, px_ready=0.
- FILL color 5'h0A, then read addresses 0, 472, 944 -> rd_q=0x0A one cycle after each address; done pulses exactly 946 cycles after accept; err=0.
- LOAD 945 pixels with data = addr mod 32, px_last on the last one, px_valid toggled randomly -> read of addr 500 gives 0x14, addr 944 gives 0x10; done pulses once; err=0.
- LOAD with px_last on pixel 100 -> done pulses and err=1; addresses 0..100 are written and addr 101 keeps its prior value. LOAD of 945 pixels without px_last -> err=1.
- POKE x=20,y=44,color=3 -> mem[944]=3 and done 2 cycles after accept. POKE x=21,y=0 -> err=1 and no RAM change. Next accepted command clears err.
- Read-during-write: read addr 7 in the same cycle FILL writes addr 7 -> old value; next read gives the new value. Assert reset_n=0 mid-FILL at cnt=300 -> IDLE next cycle, no done, addr 299 new, addr 301 old.
